writeback_pipe_stage: RTL
=========================

WRITEBACK_PIPE_STAGE -- requirements
Module: writeback_pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data path width in bits.
REQ-002 SHALL have parameter REG_AW, default 4, meaning register-file address width.
REQ-003 SHALL have parameter PIX_W, default 8, meaning pixel width, PIX_W <= DATA_W.
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of the retired-instruction counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  upstream MEM-stage result present.
REQ-009 in_ready  out  1  stage can accept this cycle.
REQ-010 mem_data  in  DATA_W  data-memory read value.
REQ-011 alu_result  in  DATA_W  ALU result.
REQ-012 pix_in  in  PIX_W  pixel byte from image memory.
REQ-013 rd_in  in  REG_AW  destination register.
REQ-014 wb_en_in  in  1  instruction writes a register.
REQ-015 sel_dat  in  2  source select: 00 ALU, 01 MEM, 10 pixel zero-extended, 11 ALU saturated to pixel range.
REQ-016 rf_we, rf_waddr[REG_AW], rf_wdata[DATA_W]  out  register-file write port.
REQ-017 pix_out  out  PIX_W  low PIX_W bits of the selected value, for the image output path.
REQ-018 out_valid  out  1  registered result present; out_ready  in  1  downstream accepts.
REQ-019 fwd_valid, fwd_addr[REG_AW], fwd_data[DATA_W]  out  forwarding bus to the decode stage.
REQ-020 retired  out  CNT_W  count of accepted results.

Function
REQ-021 SHALL compute the selected value combinationally from inputs and capture it in a one-entry pipeline register on accept (in_valid && in_ready): latency exactly 1 cycle.
REQ-022 SHALL drive in_ready = !out_valid || out_ready (holding a stalled result while accepting a new one in the same cycle that the held result leaves).
REQ-023 SHALL hold out_valid and all registered outputs stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid on the cycle after out_ready with no new accept.
REQ-025 sel_dat 10: SHALL produce {zeros, pix_in}.
REQ-026 sel_dat 11: SHALL treat alu_result as signed; negative -> 0, greater than 2^PIX_W-1 -> 2^PIX_W-1, else unchanged; result zero-extended.
REQ-027 SHALL assert rf_we = out_valid && out_ready && wb_en && (rf_waddr != 0); register 0 is never written.
REQ-028 SHALL assert fwd_valid whenever out_valid && wb_en && addr != 0, independent of out_ready, with fwd_addr/fwd_data equal to the held result.
REQ-029 SHALL increment retired by 1 on each accept, wrapping from 2^CNT_W-1 to 0 without saturation.
REQ-030 SHALL ignore in-side data when in_valid is 0; in_ready may be high.

Reset
REQ-031 On rst SHALL clear out_valid, rf_we, fwd_valid, rf_waddr, rf_wdata, pix_out, fwd_addr, fwd_data, retired to 0.
REQ-032 rst SHALL dominate a simultaneous accept: the result is discarded and retired stays 0.
REQ-033 After rst deasserts, in_ready SHALL be 1 on the first cycle.

Verification
REQ-034 sel_dat=00, alu_result=0x0000_1234, rd_in=3, wb_en_in=1, out_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234, pix_out=0x34, retired=1.
REQ-035 sel_dat=11 with alu_result 0xFFFF_FFF0, 0x0000_0120, 0x0000_007F -> rf_wdata 0x00, 0xFF, 0x7F on successive cycles.
REQ-036 out_ready=0 for 3 cycles with result rd=5 held -> out_valid=1, in_ready=0, rf_we=0, fwd_valid=1, fwd_addr=5 stable; out_ready=1 -> single rf_we pulse.
REQ-037 rd_in=0, wb_en_in=1 -> out_valid=1, rf_we=0, fwd_valid=0; retired still increments.
REQ-038 rst asserted during a stalled result -> next cycle out_valid=0, retired=0, in_ready=1.
REQ-039 CNT_W=4, 17 back-to-back accepts -> retired reads 1 (wrapped through 0 at 16).

Source files
------------

// File: rtl/writeback_pipe_stage.sv
// Writeback stage: selects the result source, holds it in a one-entry valid/ready
// register, and drives the register-file write port, forwarding bus and retire counter.
module writeback_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int PIX_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              wb_en_in,
    input  logic [1:0]        sel_dat,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [PIX_W-1:0]  pix_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired
);

    // One extra bit so the unsigned compare also works when PIX_W == DATA_W.
    localparam logic [DATA_W:0] PIX_MAX = {{(DATA_W+1-PIX_W){1'b0}}, {PIX_W{1'b1}}};

    logic              valid_q, valid_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sat_val, sel_val;
    logic              accept;

    always_comb begin
        sat_val = alu_result;
        if (alu_result[DATA_W-1])
            sat_val = '0;
        else if ({1'b0, alu_result} > PIX_MAX)
            sat_val = PIX_MAX[DATA_W-1:0];

        case (sel_dat)
            2'b00:   sel_val = alu_result;
            2'b01:   sel_val = mem_data;
            2'b10:   sel_val = DATA_W'(pix_in);
            default: sel_val = sat_val;
        endcase
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        wb_en_d = wb_en_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (accept) begin
            valid_d = 1'b1;
            wb_en_d = wb_en_in;
            addr_d  = rd_in;
            data_d  = sel_val;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            wb_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wb_en_q <= wb_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register 0 is hardwired: never written and never forwarded.
    assign fwd_valid = valid_q && wb_en_q && (addr_q != '0);
    assign rf_we     = fwd_valid && out_ready;
    assign out_valid = valid_q;
    assign rf_waddr  = addr_q;
    assign rf_wdata  = data_q;
    assign fwd_addr  = addr_q;
    assign fwd_data  = data_q;
    assign pix_out   = data_q[PIX_W-1:0];
    assign retired   = cnt_q;

endmodule
